// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the two-master Wishbone memory arbiter.
// Pulled in by wb_mem_arbiter so state names and master indices stay consistent.
package wb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GRANT_M0 = 2'd1,
        GRANT_M1 = 2'd2,
        DRAIN    = 2'd3
    } arb_state_t;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

endpackage

// File: rtl/wb_arb_timer.sv
// Saturating watchdog counter for a granted transfer.
// Raises o_terminal once the count reaches TIMEOUT_CYCLES; a zero parameter disables it.
module wb_arb_timer #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk_core,
    input  logic rst_core,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_terminal
);

    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] TC = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] r_count;

    // Holds at the terminal value instead of wrapping, so a stalled slave cannot re-arm it.
    always_ff @(posedge clk_core) begin
        if (rst_core || i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != TC)) begin
            r_count <= r_count + CW'(1);
        end
    end

    assign o_terminal = (TIMEOUT_CYCLES != 0) && (r_count == TC);

endmodule

// File: rtl/wb_mem_arbiter.sv
// Two-master (instruction fetch m0, data m1) arbiter in front of a single Wishbone memory port.
// Registered grant, combinational request/response routing, optional timeout abort.
module wb_mem_arbiter #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int RR_ENABLE      = 1
) (
    input  logic        clk_core,
    input  logic        rst_core,

    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_wstrb_i,
    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_data_i,
    output logic [31:0] m0_data_o,
    output logic        m0_ack_o,
    output logic        m0_err_o,

    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_wstrb_i,
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_data_i,
    output logic [31:0] m1_data_o,
    output logic        m1_ack_o,
    output logic        m1_err_o,

    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [3:0]  s_wstrb_o,
    output logic [31:0] s_addr_o,
    output logic [31:0] s_data_o,
    input  logic [31:0] s_data_i,
    input  logic        s_ack_i
);

    import wb_arb_pkg::*;

    arb_state_t  r_state;
    arb_state_t  w_next_state;
    logic        r_last_grant;

    logic        w_req0;
    logic        w_req1;
    logic        w_pick_m1;
    logic        w_granted;
    logic        w_sel_m1;
    logic        w_sel_cyc;
    logic        w_sel_stb;
    logic        w_sel_we;
    logic [3:0]  w_sel_wstrb;
    logic [31:0] w_sel_addr;
    logic [31:0] w_sel_data;
    logic        w_timeout;
    logic        w_ack;
    logic        w_err;
    logic [31:0] w_rdata;

    assign w_req0 = m0_cyc_i & m0_stb_i;
    assign w_req1 = m1_cyc_i & m1_stb_i;

    // On a tie, round-robin favours whoever did not win last; fixed mode always favours m0.
    always_comb begin
        w_pick_m1 = 1'b0;
        if (w_req0 && w_req1) begin
            w_pick_m1 = (RR_ENABLE != 0) && (r_last_grant == M0);
        end else begin
            w_pick_m1 = w_req1;
        end
    end

    always_ff @(posedge clk_core) begin
        if (rst_core) begin
            r_state      <= IDLE;
            r_last_grant <= M1;
        end else begin
            r_state <= w_next_state;
            if ((r_state == IDLE) && (w_req0 || w_req1)) begin
                r_last_grant <= w_pick_m1;
            end
        end
    end

    assign w_granted   = (r_state == GRANT_M0) || (r_state == GRANT_M1);
    assign w_sel_m1    = (r_state == GRANT_M1);
    assign w_sel_cyc   = w_sel_m1 ? m1_cyc_i   : m0_cyc_i;
    assign w_sel_stb   = w_sel_m1 ? m1_stb_i   : m0_stb_i;
    assign w_sel_we    = w_sel_m1 ? m1_we_i    : m0_we_i;
    assign w_sel_wstrb = w_sel_m1 ? m1_wstrb_i : m0_wstrb_i;
    assign w_sel_addr  = w_sel_m1 ? m1_addr_i  : m0_addr_i;
    assign w_sel_data  = w_sel_m1 ? m1_data_i  : m0_data_i;

    // Any grant ends on ack, abandon (cyc dropped) or timeout, always via one DRAIN cycle.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_req0 || w_req1) begin
                    w_next_state = w_pick_m1 ? GRANT_M1 : GRANT_M0;
                end
            end
            GRANT_M0, GRANT_M1: begin
                if (s_ack_i || !w_sel_cyc || w_timeout) begin
                    w_next_state = DRAIN;
                end
            end
            DRAIN:   w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    wb_arb_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk_core   (clk_core),
        .rst_core   (rst_core),
        .i_clear    (!w_granted),
        .i_enable   (w_granted && !s_ack_i),
        .o_terminal (w_timeout)
    );

    // Reset gates everything to zero in the same cycle; a real ack beats a coincident timeout.
    always_comb begin
        s_cyc_o   = 1'b0;
        s_stb_o   = 1'b0;
        s_we_o    = 1'b0;
        s_wstrb_o = 4'h0;
        s_addr_o  = 32'h0;
        s_data_o  = 32'h0;
        w_ack     = 1'b0;
        w_err     = 1'b0;
        w_rdata   = 32'h0;
        if (!rst_core && w_granted) begin
            s_we_o    = w_sel_we;
            s_wstrb_o = w_sel_wstrb;
            s_addr_o  = w_sel_addr;
            s_data_o  = w_sel_data;
            if (s_ack_i) begin
                s_cyc_o = w_sel_cyc;
                s_stb_o = w_sel_stb;
                w_ack   = 1'b1;
                w_rdata = s_data_i;
            end else if (w_timeout && w_sel_cyc) begin
                w_ack = 1'b1;
                w_err = 1'b1;
            end else begin
                s_cyc_o = w_sel_cyc;
                s_stb_o = w_sel_stb;
            end
        end
    end

    assign m0_ack_o  = w_ack & !w_sel_m1;
    assign m0_err_o  = w_err & !w_sel_m1;
    assign m0_data_o = w_sel_m1 ? 32'h0 : w_rdata;
    assign m1_ack_o  = w_ack & w_sel_m1;
    assign m1_err_o  = w_err & w_sel_m1;
    assign m1_data_o = w_sel_m1 ? w_rdata : 32'h0;

endmodule
